// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port between three
// drawing engines, with burst locking, off-screen clipping and registered outputs.
module vga_plot_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int X_MAX     = 320,
    parameter int Y_MAX     = 240
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [26:0] req_x,
    input  logic [23:0] req_y,
    input  logic [8:0]  req_color,
    input  logic [2:0]  req_last,
    output logic [2:0]  ack,
    output logic        plot,
    output logic [8:0]  X,
    output logic [7:0]  Y,
    output logic [2:0]  color,
    output logic [1:0]  grant_id,
    output logic        clip_err
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [8:0] X_LIM     = 9'(X_MAX);
    localparam logic [8:0] Y_LIM     = 9'(Y_MAX);
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    // First requesting index scanning upward from the one after the last owner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (r[first]) begin
            rr_pick = first;
        end else if (r[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  owner_r, owner_s;
    logic [1:0]  last_owner_r, last_owner_s;
    logic [7:0]  beat_cnt_r, beat_cnt_s;
    logic        plot_r, plot_s;
    logic [8:0]  x_r, x_s;
    logic [7:0]  y_r, y_s;
    logic [2:0]  color_r, color_s;
    logic        clip_err_r, clip_err_s;

    logic        sel_req_s;
    logic        sel_last_s;
    logic [8:0]  sel_x_s;
    logic [7:0]  sel_y_s;
    logic [2:0]  sel_color_s;
    logic        accept_s;
    logic        clip_s;
    logic [7:0]  beat_inc_s;

    // Select the owner's pixel slice.
    always_comb begin
        sel_req_s   = 1'b0;
        sel_last_s  = 1'b0;
        sel_x_s     = 9'd0;
        sel_y_s     = 8'd0;
        sel_color_s = 3'd0;
        case (owner_r)
            2'd0: begin
                sel_req_s = req[0]; sel_last_s = req_last[0];
                sel_x_s = req_x[8:0]; sel_y_s = req_y[7:0]; sel_color_s = req_color[2:0];
            end
            2'd1: begin
                sel_req_s = req[1]; sel_last_s = req_last[1];
                sel_x_s = req_x[17:9]; sel_y_s = req_y[15:8]; sel_color_s = req_color[5:3];
            end
            2'd2: begin
                sel_req_s = req[2]; sel_last_s = req_last[2];
                sel_x_s = req_x[26:18]; sel_y_s = req_y[23:16]; sel_color_s = req_color[8:6];
            end
            default: begin
                sel_req_s = 1'b0;
            end
        endcase
    end

    assign accept_s   = (state_r == BURST) && sel_req_s;
    // Y is zero-extended so that a limit below 256 still clips the top codes.
    assign clip_s     = (sel_x_s >= X_LIM) || ({1'b0, sel_y_s} >= Y_LIM);
    assign beat_inc_s = beat_cnt_r + 8'd1;

    // Arbitration and burst-release next-state logic.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        beat_cnt_s   = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    owner_s    = rr_pick(req, last_owner_r);
                    beat_cnt_s = 8'd0;
                    state_s    = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (sel_req_s) begin
                    beat_cnt_s = beat_inc_s;
                    if (sel_last_s || (beat_inc_s == BURST_LIM)) begin
                        state_s      = IDLE;
                        last_owner_s = owner_r;
                    end else begin
                        state_s = BURST;
                    end
                end else begin
                    state_s      = IDLE;
                    last_owner_s = owner_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pixel datapath: plot unclipped beats, hold coordinates on clipped ones.
    always_comb begin
        plot_s     = accept_s && !clip_s;
        clip_err_s = clip_err_r | (accept_s && clip_s);
        if (plot_s) begin
            x_s     = sel_x_s;
            y_s     = sel_y_s;
            color_s = sel_color_s;
        end else begin
            x_s     = x_r;
            y_s     = y_r;
            color_s = color_r;
        end
    end

    // Acknowledge decode for the current owner.
    always_comb begin
        ack = 3'b000;
        if (accept_s) begin
            case (owner_r)
                2'd0:    ack = 3'b001;
                2'd1:    ack = 3'b010;
                2'd2:    ack = 3'b100;
                default: ack = 3'b000;
            endcase
        end else begin
            ack = 3'b000;
        end
    end

    // Control state registers; last_owner resets to 2 so requester 0 wins first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            owner_r      <= 2'd0;
            last_owner_r <= 2'd2;
            beat_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            beat_cnt_r   <= beat_cnt_s;
        end
    end

    // Registered adapter-side outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            plot_r     <= 1'b0;
            x_r        <= 9'd0;
            y_r        <= 8'd0;
            color_r    <= 3'd0;
            clip_err_r <= 1'b0;
        end else begin
            plot_r     <= plot_s;
            x_r        <= x_s;
            y_r        <= y_s;
            color_r    <= color_s;
            clip_err_r <= clip_err_s;
        end
    end

    assign plot     = plot_r;
    assign X        = x_r;
    assign Y        = y_r;
    assign color    = color_r;
    assign clip_err = clip_err_r;
    assign grant_id = (state_r == BURST) ? owner_r : 2'd3;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios, a cycle model checked every
// cycle on the falling edge, and literal expectations pinning the model.
module tb_vga_plot_arbiter;
    localparam int MB = 4;
    localparam int XM = 320;
    localparam int YM = 240;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [26:0] req_x = 27'd0;
    logic [23:0] req_y = 24'd0;
    logic [8:0]  req_color = 9'd0;
    logic [2:0]  req_last = 3'b000;
    logic [2:0]  ack;
    logic        plot;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [2:0]  color;
    logic [1:0]  grant_id;
    logic        clip_err;

    vga_plot_arbiter #(.MAX_BURST(MB), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .req_last(req_last), .ack(ack), .plot(plot),
        .X(X), .Y(Y), .color(color), .grant_id(grant_id), .clip_err(clip_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int field(input logic [31:0] v, input int w, input int i);
        return int'((v >> (w * i)) & ((32'd1 << w) - 32'd1));
    endfunction

    // Abstract model: busy flag, owner, previous owner, beats taken, last output.
    bit m_busy;
    int m_owner, m_prev, m_beats;
    int m_plot, m_x, m_y, m_color, m_clip;
    int e_ack, e_gid, px, py;
    bit found;
    int grant_log[$];
    int ack_log[$];

    function automatic void model_reset();
        m_busy = 1'b0; m_owner = 0; m_prev = 2; m_beats = 0;
        m_plot = 0; m_x = 0; m_y = 0; m_color = 0; m_clip = 0;
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            model_reset();
            chk("rst_ack", 32'(ack), 0);
            chk("rst_grant", 32'(grant_id), 3);
            chk("rst_plot", 32'(plot), 0);
            chk("rst_xy", {X, Y, color}, 0);
            chk("rst_clip", 32'(clip_err), 0);
        end else begin
            e_ack = (m_busy && req[m_owner]) ? (1 << m_owner) : 0;
            e_gid = m_busy ? m_owner : 3;
            chk("ack", 32'(ack), e_ack);
            chk("grant_id", 32'(grant_id), e_gid);
            chk("plot", 32'(plot), m_plot);
            chk("X", 32'(X), m_x);
            chk("Y", 32'(Y), m_y);
            chk("color", 32'(color), m_color);
            chk("clip_err", 32'(clip_err), m_clip);
            m_plot = 0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    if (!found && req[(m_prev + k) % 3]) begin
                        found = 1'b1;
                        m_owner = (m_prev + k) % 3;
                    end
                end
                if (found) begin
                    m_busy = 1'b1;
                    m_beats = 0;
                    grant_log.push_back(m_owner);
                end
            end else if (req[m_owner]) begin
                ack_log.push_back(m_owner);
                m_beats++;
                px = field(32'(req_x), 9, m_owner);
                py = field(32'(req_y), 8, m_owner);
                if (px < XM && py < YM) begin
                    m_plot = 1;
                    m_x = px;
                    m_y = py;
                    m_color = field(32'(req_color), 3, m_owner);
                end else begin
                    m_clip = 1;
                end
                if (req_last[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0;
                    m_prev = m_owner;
                end
            end else begin
                m_busy = 1'b0;
                m_prev = m_owner;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = 3'b000; req_last = 3'b000;
        req_x = 27'd0; req_y = 24'd0; req_color = 9'd0;
        step(2);
        grant_log.delete();
        ack_log.delete();
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("init_grant", 32'(grant_id), 3);
        chk("init_plot", 32'(plot), 0);

        // Single requester 1, one-pixel burst.
        req[1] = 1'b1; req_last[1] = 1'b1;
        req_x[17:9] = 9'd10; req_y[15:8] = 8'd20; req_color[5:3] = 3'd5;
        step(1);
        chk("single_ack", 32'(ack), 32'b010);
        chk("single_gid", 32'(grant_id), 1);
        step(1);
        req = 3'b000;
        chk("single_plot", 32'(plot), 1);
        chk("single_xyc", {X, Y, color}, {9'd10, 8'd20, 3'd5});
        chk("single_idle", 32'(grant_id), 3);
        step(1);
        chk("single_plot_off", 32'(plot), 0);

        // Round robin with all requesters holding single-pixel bursts.
        do_reset();
        req_x = {9'd30, 9'd20, 9'd10};
        req_y = {8'd3, 8'd2, 8'd1};
        req_color = {3'd6, 3'd4, 3'd2};
        req_last = 3'b111;
        req = 3'b111;
        step(12);
        req = 3'b000;
        step(2);
        chk("rr_g0", grant_log[0], 0);
        chk("rr_g1", grant_log[1], 1);
        chk("rr_g2", grant_log[2], 2);
        chk("rr_g3", grant_log[3], 0);

        // Burst cap: requester 0 streams without last, requester 2 waits.
        do_reset();
        req_x = {9'd50, 9'd0, 9'd40};
        req_y = {8'd5, 8'd0, 8'd4};
        req_last = 3'b100;
        req = 3'b101;
        step(8);
        req = 3'b000;
        step(2);
        for (int i = 0; i < MB; i++) chk("cap_owner0", ack_log[i], 0);
        chk("cap_then2", ack_log[MB], 2);
        chk("cap_grants", grant_log[1], 2);

        // Clipping: x at limit, then the last on-screen corner.
        do_reset();
        req_x[8:0] = 9'd320; req_y[7:0] = 8'd5; req_color[2:0] = 3'd1;
        req = 3'b001;
        step(1);
        chk("clip_ack", 32'(ack), 32'b001);
        step(1);
        chk("clip_plot", 32'(plot), 0);
        chk("clip_flag", 32'(clip_err), 1);
        req_x[8:0] = 9'd319; req_y[7:0] = 8'd239; req_color[2:0] = 3'd7; req_last[0] = 1'b1;
        step(1);
        req = 3'b000;
        chk("clip_plot2", 32'(plot), 1);
        chk("clip_xy2", {X, Y}, {9'd319, 8'd239});
        step(2);
        chk("clip_sticky", 32'(clip_err), 1);

        // Drop-out: owner 0 withdraws mid-burst while requester 2 waits.
        do_reset();
        req_last = 3'b100;
        req = 3'b101;
        step(1);
        chk("drop_ack0", 32'(ack), 32'b001);
        step(1);
        req[0] = 1'b0;
        #1;
        chk("drop_noack", 32'(ack), 0);
        chk("drop_gid", 32'(grant_id), 0);
        step(1);
        chk("drop_idle", 32'(grant_id), 3);
        step(1);
        chk("drop_g2", 32'(grant_id), 2);
        chk("drop_ack2", 32'(ack), 32'b100);
        req = 3'b000;
        step(2);

        // Reset in the middle of a burst.
        do_reset();
        req_x[17:9] = 9'd7; req_y[15:8] = 8'd8; req_color[5:3] = 3'd3;
        req = 3'b010;
        step(2);
        chk("mid_plot", 32'(plot), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_plot", 32'(plot), 0);
        chk("mid_rst_X", 32'(X), 0);
        chk("mid_rst_gid", 32'(grant_id), 3);
        chk("mid_rst_ack", 32'(ack), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        req_last = 3'b011;
        req = 3'b011;
        step(1);
        chk("mid_prio0", 32'(grant_id), 0);
        req = 3'b000;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Three-requester arbiter that shares the single pixel-write port of the VGA adapter (plot, X, Y, color) between drawing engines: the game renderer, a HUD/overlay engine and a screen-clear engine. It grants the port in round-robin order and locks a grant for a burst of pixels, ending on a requester-marked last pixel or a maximum burst length. It clips off-screen pixels, and drives registered plot/X/Y/color into the adapter. It sits between the drawing engines and the display adapter in the top level.

## Interface
Parameters:
- MAX_BURST, 64: maximum pixels accepted per grant before forced release (1..255).
- X_MAX, 320: pixel X values >= X_MAX are clipped.
- Y_MAX, 240: pixel Y values >= Y_MAX are clipped.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  req[i]: requester i has a valid pixel presented.
- req_x  in  27  requester i pixel X in bits [9i+8:9i].
- req_y  in  24  requester i pixel Y in bits [8i+7:8i].
- req_color  in  9  requester i colour in bits [3i+2:3i].
- req_last  in  3  req_last[i]: presented pixel is the last of requester i's burst.
- ack  out  3  ack[i]: requester i's presented pixel is consumed this cycle (combinational).
- plot  out  1  registered write strobe to the adapter.
- X  out  9  registered pixel X.
- Y  out  8  registered pixel Y.
- color  out  3  registered pixel colour.
- grant_id  out  2  current owner 0..2; 3 when idle.
- clip_err  out  1  sticky flag: at least one pixel was clipped since reset.

## Operation
- FSM states: IDLE, BURST. Registers: state, owner[1:0], last_owner[1:0], beat_cnt[7:0].
- IDLE: if any req bit is high, choose the first requester with req high, scanning from (last_owner+1) mod 3 upward with wrap. Latch owner, clear beat_cnt, go to BURST. No ack is issued in IDLE. grant_id=3.
- BURST: ack[owner] = req[owner]. All other ack bits are 0. grant_id=owner.
- Accepted beat (ack[owner]=1): next cycle plot=1, with X/Y/color taken from owner's slice. Exception: if x>=X_MAX or y>=Y_MAX, then plot=0, X/Y/color hold their previous values, and clip_err is set. beat_cnt increments.
- Release to IDLE, setting last_owner=owner, when any of the following occurs:
  - an accepted beat has req_last[owner]=1;
  - an accepted beat brings beat_cnt to MAX_BURST;
  - req[owner]=0 in BURST, releasing immediately with no ack that cycle.
- Requesters must hold req/x/y/color/last stable until ack. They may change them the cycle after ack.
- Requests from non-owners are ignored until the next IDLE arbitration.
- Compare X against X_MAX with a 9-bit unsigned comparison; compare Y against Y_MAX with a 9-bit zero-extended comparison, so Y_MAX=240 clips 240..255.

## Timing
- Reset (asynchronous): state=IDLE, owner=0, last_owner=2 (requester 0 wins first), beat_cnt=0, plot=0, X=0, Y=0, color=0, clip_err=0, grant_id=3, ack=0.
- Latency: req high at edge n in IDLE → BURST at n+1 with ack high during cycle n+1 → plot high after edge n+2.
- Throughput in BURST is 1 pixel/cycle. Arbitration costs 1 dead cycle per grant.
- plot is high for exactly 1 cycle per accepted, unclipped beat. It is never high for 2 cycles on a single beat.
- Simultaneous req: resolved purely by round-robin from last_owner. The same requester cannot win twice in a row while another is requesting.
- Forced release at MAX_BURST: the owner sees ack for exactly MAX_BURST cycles, then loses the port for at least 1 cycle even if it still requests.
- Reset mid-burst: all outputs return to reset values immediately. The in-flight pixel is not plotted.
- The ack path is combinational from req[owner]. There is no combinational path from req to plot/X/Y/color.

## Test plan
- Single requester: after reset, req[1]=1 with x=10, y=20, color=5, last=1 → ack[1] 1 cycle after req, plot=1 with X=10, Y=20, color=5 on the following cycle, grant_id returns to 3.
- Round robin: req=3'b111 held, all last=1 → grants in order 0,1,2,0,… with one dead cycle between grants. plot pattern is 1,0 repeating.
- Burst cap: MAX_BURST=4, req[0] held with last=0, req[2] held → requester 0 receives exactly 4 acks, then requester 2 is granted.
- Clipping: owner presents x=320,y=5 then x=319,y=239 → first beat acked with plot=0 and clip_err=1; second beat plotted with X=319, Y=239. clip_err stays 1.
- Drop-out: owner deasserts req mid-burst while req[2]=1 → no ack that cycle, IDLE next, requester 2 granted the cycle after.
- Reset mid-burst: assert resetn=0 during an accepted beat → plot=0, X=0, grant_id=3 asynchronously. After release, requester 0 has priority.
